// File: rtl/vga_image_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_image_scanout
//  Description : VGA raster scan-out. Generates 640x480@60 timing from the
//                system clock, drives a linear address into a combinational
//                image ROM and registers the returned pixel together with
//                sync/data-enable so colour and sync leave aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_image_scanout #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              blank,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frame_start
);

   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_DW      = $clog2(CLK_DIV);
   localparam int c_HW      = $clog2(c_H_TOTAL);
   localparam int c_VW      = $clog2(c_V_TOTAL);

   localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
   localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
   localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
   localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
   localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
   localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
   localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
   localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [c_DW-1:0]   r_div_cnt;
   logic [c_HW-1:0]   r_h_cnt;
   logic [c_VW-1:0]   r_v_cnt;
   logic [ADDR_W-1:0] r_addr_cnt;
   logic [11:0]       r_rgb;
   logic              r_de;
   logic              r_hsync;
   logic              r_vsync;
   logic              r_frame_start;

   logic w_tick;
   logic w_h_last;
   logic w_v_last;
   logic w_frame_wrap;
   logic w_active;
   logic w_hs;
   logic w_vs;

   // Pixel-rate strobe and raster decode of the current (pre-advance) position
   always_comb begin
      w_tick       = (r_div_cnt == c_DIV_LAST);
      w_h_last     = (r_h_cnt == c_H_LAST);
      w_v_last     = (r_v_cnt == c_V_LAST);
      w_frame_wrap = w_h_last && w_v_last;
      w_active     = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
      w_hs         = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
      w_vs         = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));
   end

   // System-clock divider producing one tick per pixel period
   always_ff @(posedge clk) begin
      if (rst || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + c_DW'(1);
      end
   end

   // Horizontal/vertical raster counters, advanced on the pixel tick
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_tick) begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + c_VW'(1);
         end else begin
            r_h_cnt <= r_h_cnt + c_HW'(1);
         end
      end
   end

   // Linear ROM address: steps through visible pixels only, so it tracks
   // v*H_ACTIVE+h without a multiplier and parks during blanking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_cnt <= '0;
      end else if (w_tick) begin
         if (w_frame_wrap) begin
            r_addr_cnt <= '0;
         end else if (w_active) begin
            r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
         end
      end
   end

   // Output stage: pixel and sync registered together, one pixel period behind
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rgb   <= 12'h000;
         r_de    <= 1'b0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else if (w_tick) begin
         r_rgb   <= (w_active && !blank) ? rom_data : 12'h000;
         r_de    <= w_active;
         r_hsync <= w_hs;
         r_vsync <= w_vs;
      end
   end

   // Single-cycle frame marker following the tick that wraps to (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_tick && w_frame_wrap;
      end
   end

   assign rom_addr    = r_addr_cnt;
   assign vga_r       = r_rgb[11:8];
   assign vga_g       = r_rgb[7:4];
   assign vga_b       = r_rgb[3:0];
   assign de          = r_de;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_image_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_image_scanout
//  Description : Self-checking bench for vga_image_scanout. Full horizontal
//                timing, shortened vertical timing (8 visible lines, 15 total)
//                so whole frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_image_scanout;

   localparam int CLK_DIV  = 4;
   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int V_ACTIVE = 8;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME_PX = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        blank = 1'b0;
   logic [18:0] rom_addr;
   logic [11:0] rom_data;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        hsync, vsync, de, frame_start;

   vga_image_scanout #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .ADDR_W(19)
   ) dut (
      .clk(clk), .rst(rst), .blank(blank), .rom_addr(rom_addr), .rom_data(rom_data),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
      .de(de), .frame_start(frame_start)
   );

   // Model ROM: pixel value is the low 12 bits of the address
   assign rom_data = rom_addr[11:0];

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Clocks since reset release (edge k after release reads k)
   int cyc = 0;
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Edge-time monitor for sync geometry and frame_start pulses
   int  fs_pulses = 0, fs_first = -1;
   int  hs_falls = 0, hs_fall0 = -1, hs_fall1 = -1, hs_rise0 = -1;
   int  vs_fall0 = -1, vs_rise0 = -1;
   bit  prev_hs = 1'b1, prev_vs = 1'b1;
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_start === 1'b1) begin
            fs_pulses++;
            if (fs_first < 0) fs_first = cyc;
         end
         if (prev_hs && hsync === 1'b0) begin
            if (hs_falls == 0) hs_fall0 = cyc;
            if (hs_falls == 1) hs_fall1 = cyc;
            hs_falls++;
         end
         if (!prev_hs && hsync === 1'b1 && hs_rise0 < 0) hs_rise0 = cyc;
         if (prev_vs && vsync === 1'b0 && vs_fall0 < 0) vs_fall0 = cyc;
         if (!prev_vs && vsync === 1'b1 && vs_rise0 < 0) vs_rise0 = cyc;
         prev_hs = (hsync !== 1'b0);
         prev_vs = (vsync !== 1'b0);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Expected ROM address while the raster sits at (h,v)
   function automatic int exp_addr(input int h, input int v);
      if (v < V_ACTIVE && h < H_ACTIVE) return v * H_ACTIVE + h;
      else if (v < V_ACTIVE)            return (v + 1) * H_ACTIVE;
      else                              return V_ACTIVE * H_ACTIVE;
   endfunction

   typedef struct {
      int p;      // pixel index since reset release (frame*FRAME_PX + v*800 + h)
      int addr;   // rom_addr while at that pixel
      int rgb;    // output colour (previous pixel)
      bit de;
      bit hs;
      bit vs;
      bit fs;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int f, input int h, input int v, input int addr, input int rgb,
                      input bit d, input bit hs, input bit vs, input bit fs);
      vec_t e;
      e.p = f * FRAME_PX + v * H_TOTAL + h;
      e.addr = addr; e.rgb = rgb; e.de = d; e.hs = hs; e.vs = vs; e.fs = fs;
      tbl.push_back(e);
   endtask

   int cur_h = 0, cur_v = 0, prev_h = 0, prev_v = 0;
   bit cur_blank = 1'b0, prev_blank = 1'b0;

   task automatic tick_adv();
      repeat (CLK_DIV) @(posedge clk);
      #1;
      prev_h = cur_h; prev_v = cur_v; prev_blank = cur_blank;
      cur_h++;
      if (cur_h == H_TOTAL) begin
         cur_h = 0;
         cur_v++;
         if (cur_v == V_TOTAL) cur_v = 0;
      end
   endtask

   initial begin : main
      int ti;
      int err_addr, err_de, err_rgb, err_sync, err_fs, de_ones;
      int ea, erg;
      bit ed, ehs, evs;
      logic [11:0] rgb;
      string nm;

      //   frame h    v   addr  rgb    de hs vs fs
      add(0,   1,  0,    1, 12'h000, 1, 1, 1, 0);
      add(0,   2,  0,    2, 12'h001, 1, 1, 1, 0);
      add(0, 656,  0,  640, 12'h000, 0, 1, 1, 0);
      add(0, 657,  0,  640, 12'h000, 0, 0, 1, 0);
      add(0, 752,  0,  640, 12'h000, 0, 0, 1, 0);
      add(0, 753,  0,  640, 12'h000, 0, 1, 1, 0);
      add(0,   0,  1,  640, 12'h000, 0, 1, 1, 0);
      add(0,   1,  1,  641, 12'h280, 1, 1, 1, 0);
      add(0, 399,  1, 1039, 12'h40E, 1, 1, 1, 0);
      add(0, 640,  1, 1280, 12'h4FF, 1, 1, 1, 0);
      add(0, 641,  1, 1280, 12'h000, 0, 1, 1, 0);
      add(0, 100,  5, 3300, 12'hCE3, 1, 1, 1, 0);
      add(0, 101,  5, 3301, 12'h000, 1, 1, 1, 0);
      add(0, 110,  5, 3310, 12'h000, 1, 1, 1, 0);
      add(0, 111,  5, 3311, 12'hCEE, 1, 1, 1, 0);
      add(0, 639,  7, 5119, 12'h3FE, 1, 1, 1, 0);
      add(0, 640,  7, 5120, 12'h3FF, 1, 1, 1, 0);
      add(0,   0,  8, 5120, 12'h000, 0, 1, 1, 0);
      add(0,   0, 10, 5120, 12'h000, 0, 1, 1, 0);
      add(0,   1, 10, 5120, 12'h000, 0, 1, 0, 0);
      add(0,   0, 12, 5120, 12'h000, 0, 1, 0, 0);
      add(0,   1, 12, 5120, 12'h000, 0, 1, 1, 0);
      add(0, 799, 14, 5120, 12'h000, 0, 1, 1, 0);
      add(1,   0,  0,    0, 12'h000, 0, 1, 1, 1);
      add(1,   1,  0,    1, 12'h000, 1, 1, 1, 0);
      add(1,   2,  0,    2, 12'h001, 1, 1, 1, 0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs {addr,rgb,de,hs,vs,fs}",
            {rom_addr, vga_r, vga_g, vga_b, de, hsync, vsync, frame_start},
            {19'd0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      rst = 1'b0;

      ti = 0;
      err_addr = 0; err_de = 0; err_rgb = 0; err_sync = 0; err_fs = 0; de_ones = 0;
      for (int n = 1; n <= FRAME_PX + 4 * H_TOTAL + 320; n++) begin
         tick_adv();
         rgb = {vga_r, vga_g, vga_b};
         ed  = (prev_h < H_ACTIVE) && (prev_v < V_ACTIVE);
         ea  = exp_addr(prev_h, prev_v);
         erg = (ed && !prev_blank) ? (ea & 12'hFFF) : 0;
         ehs = !(prev_h >= 656 && prev_h < 752);
         evs = !(prev_v >= V_ACTIVE + V_FP && prev_v < V_ACTIVE + V_FP + V_SYNC);
         if (int'(rom_addr) != exp_addr(cur_h, cur_v) || $isunknown(rom_addr)) err_addr++;
         if (de !== ed) err_de++;
         if (rgb !== 12'(erg)) err_rgb++;
         if (hsync !== ehs || vsync !== evs) err_sync++;
         if (frame_start !== (cur_h == 0 && cur_v == 0)) err_fs++;
         if (n <= FRAME_PX && de === 1'b1) de_ones++;
         if (ti < tbl.size() && tbl[ti].p == n) begin
            nm = $sformatf("vec[%0d] h=%0d v=%0d {addr,rgb,de,hs,vs,fs}", ti, cur_h, cur_v);
            check(nm, {1'b0, rom_addr, rgb, de, hsync, vsync, frame_start},
                  {1'b0, 19'(tbl[ti].addr), 12'(tbl[ti].rgb), tbl[ti].de, tbl[ti].hs,
                   tbl[ti].vs, tbl[ti].fs});
            ti++;
         end
         // blank covers pixels 100..109 of line 5 in the first frame only
         cur_blank = (n < FRAME_PX) && (cur_v == 5) && (cur_h >= 100) && (cur_h <= 109);
         blank = cur_blank;
      end

      check("sweep rom_addr errors", err_addr, 0);
      check("sweep de errors", err_de, 0);
      check("sweep rgb errors", err_rgb, 0);
      check("sweep sync errors", err_sync, 0);
      check("sweep frame_start errors", err_fs, 0);
      check("de=1 pixels per frame", de_ones, H_ACTIVE * V_ACTIVE);
      check("hsync first fall clock", hs_fall0, 657 * CLK_DIV);
      check("line period clocks", hs_fall1 - hs_fall0, H_TOTAL * CLK_DIV);
      check("hsync low width clocks", hs_rise0 - hs_fall0, 96 * CLK_DIV);
      check("vsync first fall clock", vs_fall0, ((V_ACTIVE + V_FP) * H_TOTAL + 1) * CLK_DIV);
      check("vsync low width clocks", vs_rise0 - vs_fall0, V_SYNC * H_TOTAL * CLK_DIV);
      check("first frame_start clock", fs_first, FRAME_PX * CLK_DIV);

      // Mid-frame reset at (320,4): outputs return to reset values on the next edge
      check("pre-reset rom_addr at (320,4)", rom_addr, 4 * H_ACTIVE + 320);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid-frame reset outputs {addr,rgb,de,hs,vs,fs}",
            {rom_addr, vga_r, vga_g, vga_b, de, hsync, vsync, frame_start},
            {19'd0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0});
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (CLK_DIV - 1) @(posedge clk);
      #1;
      check("no tick before 4th clock {addr,de}", {rom_addr, de}, {19'd0, 1'b0});
      @(posedge clk);
      #1;
      check("first tick after restart {addr,rgb,de}",
            {rom_addr, vga_r, vga_g, vga_b, de}, {19'd1, 12'h000, 1'b1});
      repeat (CLK_DIV) @(posedge clk);
      #1;
      check("second tick after restart {addr,rgb,de}",
            {rom_addr, vga_r, vga_g, vga_b, de}, {19'd2, 12'h001, 1'b1});
      check("total frame_start pulses", fs_pulses, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
